instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- IF stage plus IF/ID pipeline register; directly upstream of the decoder and immediate generator.
- Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake, with one request outstanding at a time.
- Delivers instr_d, pc_d and pc_plus4_d to decode. Absorbs decode stalls with a one-entry hold buffer and honours EX-stage redirects (branch/jump).

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven on instr_d when valid_d=0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; always pc_f.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; at least 1 cycle after gnt.
- imem_rdata  in  32  fetched instruction.
- stall_d  in  1  decode cannot accept; IF/ID register holds.
- redirect_e  in  1  taken branch/jump from EX.
- redirect_target_e  in  32  new PC.
- instr_d  out  32  instruction to decode/immediate generator.
- pc_d  out  32  PC of instr_d.
- pc_plus4_d  out  32  pc_d+4, modulo 2^32.
- valid_d  out  1  instr_d is real (not bubble).

Behaviour:
- Reset (async):
  - pc_f=RESET_VECTOR, state=REQ.
  - valid_d=0, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, hold buffer empty.
- imem_req=1 only in REQ. imem_addr=pc_f in all states.
- States and transitions:
  - REQ:
    - gnt & !redirect_e -> WAIT.
    - gnt & redirect_e -> KILL; pc_f<=target.
    - !gnt & redirect_e -> stay REQ; pc_f<=target. Address may change because the request was not granted.
  - WAIT:
    - rvalid & redirect_e -> discard the response; pc_f<=target; -> REQ.
    - rvalid & !stall_d -> load IF/ID (instr_d=rdata, pc_d=pc_f, valid_d=1); pc_f<=pc_f+4; -> REQ.
    - rvalid & stall_d -> capture rdata/pc_f into hold buffer; pc_f<=pc_f+4; -> HOLD.
    - !rvalid & redirect_e -> pc_f<=target; -> KILL.
  - KILL: rvalid -> drop the response; -> REQ. Further redirects update pc_f and stay KILL.
  - HOLD:
    - redirect_e -> clear buffer; pc_f<=target; -> REQ.
    - !stall_d -> load IF/ID from buffer; -> REQ.
- IF/ID register:
  - stall_d=1 and redirect_e=0: all *_d outputs hold.
  - redirect_e=1 (priority over stall_d): valid_d<=0, instr_d<=NOP_INSTR.
  - stall_d=0 and no instruction available: bubble (valid_d<=0, instr_d<=NOP_INSTR; pc_d and pc_plus4_d hold).
- Latency: best case gnt in the same cycle as req and rvalid one cycle later.
  - instr_d appears 2 cycles after req.
  - Throughput is 1 instruction per 2 cycles (single outstanding request).
- PC arithmetic wraps: 32'hFFFF_FFFC+4=0.
- Redirect target bits [1:0] are passed through unchanged; alignment checking belongs to EX.
- Reset asserted mid-transaction: the outstanding response is lost. The memory side must also be reset, and any rvalid arriving in REQ after reset is ignored.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_count[31:0], counting cycles where IF/ID loads a valid instruction.
  - Adds outputs perf_bubble_count[31:0], counting cycles where valid_d<=0 while stall_d=0.
  - Both counters reset to 0 on rst and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, memory gives gnt immediately and rvalid 1 cycle later with data 0x00500093 -> imem_addr=0x0, then 0x4. instr_d=0x00500093, pc_d=0x0, pc_plus4_d=0x4, valid_d=1 two cycles after the first req.
- stall_d=1 for 3 cycles while the response for 0x4 arrives -> *_d outputs unchanged, state HOLD. On release, instr_d holds the buffered word with pc_d=0x4, then imem_addr=0x8.
- redirect_e with target 0x100 in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF is never seen on instr_d. Next request has imem_addr=0x100 and valid_d=0 in between.
- redirect_e and rvalid in the same cycle -> response dropped, pc_f=target, instr_d=0x00000013, valid_d=0.
- pc_f=0xFFFFFFFC, fetch completes -> pc_plus4_d=0x0, next imem_addr=0x0.
- With IFETCH_PERF_CNT_EN: run 4 fetches and 1 redirect -> perf_fetch_count=4, perf_bubble_count equals the observed valid_d=0 cycles while stall_d=0.

Source files
------------

// File: rtl/instruction_fetch_stage_if.sv
// instruction_fetch_stage_if: single-outstanding instruction-memory fetch bus (req/gnt/rvalid).
interface instruction_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC, single-outstanding imem fetch, one-entry decode hold buffer and IF/ID register.
// Define IFETCH_PERF_CNT_EN to add perf_fetch_count / perf_bubble_count outputs.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  instruction_fetch_stage_if.master  imem,
  input  logic                       stall_d,
  input  logic                       redirect_e,
  input  logic [31:0]                redirect_target_e,
  output logic [31:0]                instr_d,
  output logic [31:0]                pc_d,
  output logic [31:0]                pc_plus4_d,
  output logic                       valid_d
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]                perf_fetch_count,
  output logic [31:0]                perf_bubble_count
`endif
);
  typedef enum logic [1:0] {REQ, WAIT, KILL, HOLD} state_t;
  state_t      state, state_nx;
  logic [31:0] pc_f, pc_nx, hold_instr, hold_pc, id_instr, id_pc;
  logic        hold_load, id_load;
  assign imem.req  = state == REQ;
  assign imem.addr = pc_f;
  always_comb begin
    state_nx  = state;
    pc_nx     = pc_f;
    hold_load = 1'b0;
    id_load   = 1'b0;
    id_instr  = hold_instr;
    id_pc     = hold_pc;
    case (state)
      REQ: begin
        pc_nx    = redirect_e ? redirect_target_e : pc_f;
        state_nx = imem.gnt ? (redirect_e ? KILL : WAIT) : REQ;
      end
      WAIT: begin
        if (imem.rvalid) begin
          state_nx  = (redirect_e || !stall_d) ? REQ : HOLD;
          pc_nx     = redirect_e ? redirect_target_e : pc_f + 32'd4;
          hold_load = !redirect_e && stall_d;
          id_load   = !redirect_e && !stall_d;
          id_instr  = imem.rdata;
          id_pc     = pc_f;
        end else if (redirect_e) begin
          state_nx = KILL;
          pc_nx    = redirect_target_e;
        end
      end
      KILL: begin
        // the in-flight response belongs to a squashed path and is dropped on arrival
        pc_nx    = redirect_e ? redirect_target_e : pc_f;
        state_nx = imem.rvalid ? REQ : KILL;
      end
      default: begin
        pc_nx    = redirect_e ? redirect_target_e : pc_f;
        state_nx = (redirect_e || !stall_d) ? REQ : HOLD;
        id_load  = !redirect_e && !stall_d;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= REQ;
      pc_f       <= RESET_VECTOR;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      state <= state_nx;
      pc_f  <= pc_nx;
      if (hold_load) begin
        hold_instr <= imem.rdata;
        hold_pc    <= pc_f;
      end
    end
  end
  // redirect outranks stall; id_load already excludes both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_d    <= 1'b0;
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
    end else if (redirect_e || (!stall_d && !id_load)) begin
      valid_d <= 1'b0;
      instr_d <= NOP_INSTR;
    end else if (id_load) begin
      valid_d    <= 1'b1;
      instr_d    <= id_instr;
      pc_d       <= id_pc;
      pc_plus4_d <= id_pc + 32'd4;
    end
  end
`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_count  <= '0;
      perf_bubble_count <= '0;
    end else begin
      perf_fetch_count  <= perf_fetch_count + {31'd0, id_load};
      perf_bubble_count <= perf_bubble_count + {31'd0, !stall_d && !id_load};
    end
  end
`endif
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: directed fetch/stall/redirect/wrap sequence, then randomized traffic
// checked against a program-order model (next delivered PC = previous + 4, or the latest redirect target).
`timescale 1ns/1ps
module tb_instruction_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0, rst = 1'b1, stall_d = 1'b0, redirect_e = 1'b0, valid_d;
  logic [31:0] redirect_target_e = '0, instr_d, pc_d, pc_plus4_d;
  int          n_cmp = 0, n_bad = 0, gnt_pct = 100, lat_min = 1, lat_max = 1;
  int          n_fetch = 0, n_bubble = 0, cnt = 0;
  bit          busy = 0;
  logic [31:0] paddr = '0, special_addr = 32'h8, special_data = 32'hDEAD_BEEF;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_count, perf_bubble_count;
`endif
  instruction_fetch_stage_if bus ();
  instruction_fetch_stage dut (
    .clk(clk), .rst(rst), .imem(bus), .stall_d(stall_d), .redirect_e(redirect_e),
    .redirect_target_e(redirect_target_e), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
`ifdef IFETCH_PERF_CNT_EN
    , .perf_fetch_count(perf_fetch_count), .perf_bubble_count(perf_bubble_count)
`endif
  );
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == special_addr) return special_data;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] p4);
    chk({tag, ".valid"}, 32'(valid_d), 32'(v));
    chk({tag, ".instr"}, instr_d, i);
    chk({tag, ".pc"}, pc_d, p);
    chk({tag, ".pc4"}, pc_plus4_d, p4);
  endtask

  task automatic chk_bus(input string tag, input logic r, input logic [31:0] a);
    chk({tag, ".req"}, 32'(bus.req), 32'(r));
    chk({tag, ".addr"}, bus.addr, a);
  endtask

  // memory: one outstanding request, rvalid lat_min..lat_max cycles after gnt, junk rdata otherwise
  initial begin
    bus.gnt = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata = '0;
    forever begin
      step();
      bus.gnt = 1'b0;
      bus.rvalid = 1'b0;
      bus.rdata = $urandom;
      if (rst) busy = 0;
      else if (busy) begin
        if (cnt == 1) begin
          bus.rvalid = 1'b1;
          bus.rdata = mem_word(paddr);
          busy = 0;
        end else cnt--;
      end else if (bus.req && int'($urandom_range(99)) < gnt_pct) begin
        bus.gnt = 1'b1;
        busy = 1;
        paddr = bus.addr;
        cnt = int'($urandom_range(lat_max, lat_min));
      end
    end
  end

  initial begin
    logic        p_stall, p_redir, o_valid;
    logic [31:0] p_tgt, nxt_pc, o_instr, o_pc, o_p4;
    step();
    chk_id("reset", 0, NOP, 0, 0);
    chk_bus("reset", 1, 0);
    @(negedge clk) rst = 1'b0;
    step();
    chk_id("e1", 0, NOP, 0, 0);
    chk_bus("e1", 1, 0);
    step();
    chk_bus("e2_wait", 0, 0);
    step();
    chk_id("first_fetch", 1, 32'h0050_0093, 0, 4);
    chk_bus("first_fetch", 1, 4);
    stall_d = 1'b1;
    step();
    chk_id("stall1", 1, 32'h0050_0093, 0, 4);
    chk_bus("stall1", 0, 4);
    step();
    chk_id("stall2", 1, 32'h0050_0093, 0, 4);
    chk_bus("hold", 0, 8);
    step();
    chk_id("stall3", 1, 32'h0050_0093, 0, 4);
    chk_bus("hold2", 0, 8);
    stall_d = 1'b0;
    lat_min = 3;
    lat_max = 3;
    step();
    chk_id("unhold", 1, mem_word(4), 4, 8);
    chk_bus("unhold", 1, 8);
    step();
    chk_id("bubble_wait", 0, NOP, 4, 8);
    chk_bus("wait8", 0, 8);
    redirect_e = 1'b1;
    redirect_target_e = 32'h100;
    lat_min = 1;
    lat_max = 1;
    step();
    redirect_e = 1'b0;
    chk_id("redir_wait", 0, NOP, 4, 8);
    chk_bus("kill", 0, 32'h100);
    step();
    chk_id("kill1", 0, NOP, 4, 8);
    step();
    chk_id("kill_drop", 0, NOP, 4, 8);
    chk("no_stale", 32'(instr_d == special_data), 0);
    chk_bus("after_kill", 1, 32'h100);
    step();
    chk("no_stale2", 32'(instr_d == special_data), 0);
    step();
    chk_id("target_fetch", 1, mem_word(32'h100), 32'h100, 32'h104);
    chk_bus("target_fetch", 1, 32'h104);
    step();
    redirect_e = 1'b1;
    redirect_target_e = 32'hFFFF_FFFC;
    step();
    redirect_e = 1'b0;
    chk_id("redir_rvalid", 0, NOP, 32'h100, 32'h104);
    chk_bus("redir_rvalid", 1, 32'hFFFF_FFFC);
    step();
    chk("wrap_wait_valid", 32'(valid_d), 0);
    step();
    chk_id("wrap", 1, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0);
    chk_bus("wrap", 1, 32'h0);
    step();
    #1 rst = 1'b1;
    #1 chk_id("async_rst", 0, NOP, 0, 0);
    chk_bus("async_rst", 1, 0);
    step();
    @(negedge clk) rst = 1'b0;
    gnt_pct = 60;
    lat_max = 3;
    nxt_pc = 32'h0;
    {o_valid, o_instr, o_pc, o_p4} = {1'b0, NOP, 32'h0, 32'h0};
    for (int c = 0; c < 3000; c++) begin
      stall_d = int'($urandom_range(99)) < 30;
      redirect_e = int'($urandom_range(99)) < 6;
      case ($urandom_range(2))
        0: redirect_target_e = 32'($urandom_range(1023)) << 2;
        1: redirect_target_e = 32'hFFFF_FFF0 + (32'($urandom_range(3)) << 2);
        default: redirect_target_e = $urandom;
      endcase
      {p_stall, p_redir, p_tgt} = {stall_d, redirect_e, redirect_target_e};
      step();
      if (!p_stall && !valid_d) n_bubble++;
      if (p_redir) begin
        nxt_pc = p_tgt;
        chk("rnd_redir_valid", 32'(valid_d), 0);
        chk("rnd_redir_instr", instr_d, NOP);
      end else if (p_stall) begin
        chk("rnd_hold_valid", 32'(valid_d), 32'(o_valid));
        chk("rnd_hold_instr", instr_d, o_instr);
        chk("rnd_hold_pc", pc_d, o_pc);
        chk("rnd_hold_pc4", pc_plus4_d, o_p4);
      end else if (valid_d) begin
        chk("rnd_fetch_pc", pc_d, nxt_pc);
        chk("rnd_fetch_instr", instr_d, mem_word(nxt_pc));
        chk("rnd_fetch_pc4", pc_plus4_d, nxt_pc + 32'd4);
        nxt_pc = nxt_pc + 32'd4;
        n_fetch++;
      end else begin
        chk("rnd_bubble_instr", instr_d, NOP);
        chk("rnd_bubble_pc", pc_d, o_pc);
        chk("rnd_bubble_pc4", pc_plus4_d, o_p4);
      end
      {o_valid, o_instr, o_pc, o_p4} = {valid_d, instr_d, pc_d, pc_plus4_d};
    end
    chk("liveness", 32'(n_fetch > 100), 1);
`ifdef IFETCH_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_count, 32'(n_fetch));
    chk("perf_bubble", perf_bubble_count, 32'(n_bubble));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
